// File: rtl/dma_utils_pkg.sv
// Shared types for the DMA streamer: descriptor/request structs, streamer
// state encodings and AXI burst-type encodings.
package dma_utils_pkg;

  localparam int DMA_NUM_DESC = 2;
  localparam int DMA_IDX_W    = 1;
  localparam int DMA_ADDR_W   = 32;
  localparam int DMA_BYTES_W  = 32;

  localparam logic DMA_MODE_INCR  = 1'b0;
  localparam logic DMA_MODE_FIXED = 1'b1;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef logic [1:0] dma_strm_st_t;
  localparam dma_strm_st_t DMA_ST_IDLE = 2'd0;
  localparam dma_strm_st_t DMA_ST_CALC = 2'd1;
  localparam dma_strm_st_t DMA_ST_REQ  = 2'd2;
  localparam dma_strm_st_t DMA_ST_DONE = 2'd3;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0]  src_addr;
    logic [DMA_ADDR_W-1:0]  dst_addr;
    logic [DMA_BYTES_W-1:0] num_bytes;
    logic                   rd_mode;
    logic                   wr_mode;
  } s_dma_desc_t;

  typedef struct packed {
    logic                 valid;
    logic [DMA_IDX_W-1:0] idx;
  } s_dma_str_in_t;

  typedef struct packed {
    logic done;
  } s_dma_str_out_t;

endpackage

// File: rtl/dma_streamer_if.sv
// Burst request channel between a DMA streamer and the AXI master address side.
interface dma_streamer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_alen;
  logic [2:0]        req_size;
  logic [1:0]        req_burst;

  modport master (
    output req_valid, req_addr, req_alen, req_size, req_burst,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_alen, req_size, req_burst,
    output req_ready
  );
endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizer: min(beats_left, burst cap, beats to the next 4 KB
// boundary), the boundary term only applying to INCR bursts.
module dma_burst_calc #(
  parameter int BYTES     = 4,
  parameter int BYTES_W   = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic [BYTES_W-1:0] beats_left_i,
  input  logic [11:0]        addr_lo_i,
  input  logic               fixed_i,
  output logic [8:0]         beats_o
);

  localparam int LIM_W = (BYTES_W > 16) ? BYTES_W : 16;

  logic [LIM_W-1:0] cap;
  logic [LIM_W-1:0] to4k;
  logic [LIM_W-1:0] lim;

  always_comb begin
    cap  = fixed_i ? LIM_W'(16) : LIM_W'(MAX_BEATS);
    to4k = LIM_W'(13'h1000 - {1'b0, addr_lo_i}) / LIM_W'(BYTES);
    lim  = cap;
    if (!fixed_i && (to4k < lim)) lim = to4k;
    if (LIM_W'(beats_left_i) < lim) lim = LIM_W'(beats_left_i);
    // An unaligned start a few bytes below 4 KB must still make progress
    if (lim == '0) lim = LIM_W'(1);
    beats_o = 9'(lim);
  end

endmodule

// File: rtl/dma_streamer.sv
// Per-direction DMA streamer: fetches a descriptor on request, splits it into
// AXI-legal bursts on the request channel and pulses done after the last one.
module dma_streamer
  import dma_utils_pkg::*;
#(
  parameter int RD_STREAM = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BYTES_W   = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  s_dma_desc_t    dma_desc_i [DMA_NUM_DESC],
  input  s_dma_str_in_t  dma_stream_i,
  output s_dma_str_out_t dma_stream_o,
  input  logic           dma_abort_i,
  input  logic           clear_dma_i,
  dma_streamer_if.master req_if,
  output logic           busy_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);

  dma_strm_st_t       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BYTES_W-1:0] beats_left_q, beats_left_d;
  logic               fixed_q, fixed_d;
  logic [7:0]         alen_q, alen_d;
  logic               abort_q, abort_d;

  s_dma_desc_t        sel_desc;
  logic [8:0]         calc_beats;
  logic [BYTES_W-1:0] req_beats;

  dma_burst_calc #(
    .BYTES    (BYTES),
    .BYTES_W  (BYTES_W),
    .MAX_BEATS(MAX_BEATS)
  ) u_calc (
    .beats_left_i(beats_left_q),
    .addr_lo_i   (addr_q[11:0]),
    .fixed_i     (fixed_q),
    .beats_o     (calc_beats)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    fixed_d      = fixed_q;
    alen_d       = alen_q;
    abort_d      = abort_q;
    sel_desc     = dma_desc_i[dma_stream_i.idx];
    req_beats    = BYTES_W'(alen_q) + BYTES_W'(1);

    if ((state_q != DMA_ST_IDLE) && dma_abort_i) abort_d = 1'b1;

    case (state_q)
      DMA_ST_IDLE: begin
        abort_d = 1'b0;
        if (dma_stream_i.valid) begin
          addr_d       = ADDR_W'((RD_STREAM != 0) ? sel_desc.src_addr : sel_desc.dst_addr);
          beats_left_d = BYTES_W'(sel_desc.num_bytes / DMA_BYTES_W'(BYTES))
                       + BYTES_W'((sel_desc.num_bytes % DMA_BYTES_W'(BYTES)) != '0);
          fixed_d      = ((RD_STREAM != 0) ? sel_desc.rd_mode : sel_desc.wr_mode) == DMA_MODE_FIXED;
          state_d      = (sel_desc.num_bytes == '0) ? DMA_ST_DONE : DMA_ST_CALC;
        end
      end
      DMA_ST_CALC: begin
        alen_d  = 8'(calc_beats - 9'd1);
        state_d = DMA_ST_REQ;
      end
      DMA_ST_REQ: begin
        if (req_if.req_ready) begin
          beats_left_d = beats_left_q - req_beats;
          if (!fixed_q) addr_d = addr_q + (ADDR_W'(alen_q) + ADDR_W'(1)) * ADDR_W'(BYTES);
          // An abort lets the in-flight request finish, then ends the stream
          state_d = ((beats_left_d == '0) || abort_d) ? DMA_ST_DONE : DMA_ST_CALC;
        end
      end
      DMA_ST_DONE: state_d = DMA_ST_IDLE;
      default:     state_d = DMA_ST_IDLE;
    endcase

    if (clear_dma_i) begin
      state_d = DMA_ST_IDLE;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DMA_ST_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      fixed_q      <= 1'b0;
      alen_q       <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      fixed_q      <= fixed_d;
      alen_q       <= alen_d;
      abort_q      <= abort_d;
    end
  end

  assign req_if.req_valid  = (state_q == DMA_ST_REQ);
  assign req_if.req_addr   = addr_q;
  assign req_if.req_alen   = alen_q;
  assign req_if.req_size   = 3'(SZ);
  assign req_if.req_burst  = fixed_q ? AXI_BURST_FIXED : AXI_BURST_INCR;
  assign dma_stream_o.done = (state_q == DMA_ST_DONE);
  assign busy_o            = (state_q != DMA_ST_IDLE);

endmodule

// File: tb/tb_dma_streamer.sv
// Self-checking bench for dma_streamer (read side, 32-bit data): table-driven
// transfers checked through a burst scoreboard, plus abort/reset/clear sequences.
module tb_dma_streamer;
  import dma_utils_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  s_dma_desc_t    desc [DMA_NUM_DESC];
  s_dma_str_in_t  str_in;
  s_dma_str_out_t str_out;
  logic           abort_i;
  logic           clear_i;
  logic           busy;

  dma_streamer_if #(.ADDR_W(32)) req_if ();

  dma_streamer #(
    .RD_STREAM(1),
    .ADDR_W   (32),
    .DATA_W   (32),
    .BYTES_W  (32),
    .MAX_BEATS(256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dma_desc_i  (desc),
    .dma_stream_i(str_in),
    .dma_stream_o(str_out),
    .dma_abort_i (abort_i),
    .clear_dma_i (clear_i),
    .req_if      (req_if),
    .busy_o      (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [1:0]  burst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] nbytes;
    logic        fixed;
    int          stall;
    int          n;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [7:0]  l0;
    logic [7:0]  l1;
  } vec_t;

  exp_t        exp_q [$];
  exp_t        cur;
  vec_t        vecs [7];
  int          checks = 0;
  int          failures = 0;
  int          stall_left = 0;
  logic        done_pend = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr;
  logic [7:0]  stall_alen;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] addr, input logic [7:0] alen, input logic fixed);
    exp_t e;
    e.addr  = addr;
    e.alen  = alen;
    e.burst = fixed ? 2'b00 : 2'b01;
    exp_q.push_back(e);
  endtask

  // Present a one-cycle request and check the CALC gap and REQ latency
  task automatic applyStimulus(input logic [DMA_IDX_W-1:0] idx);
    @(posedge clk); #1;
    str_in.valid = 1'b1;
    str_in.idx   = idx;
    @(posedge clk); #1;
    str_in.valid = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'(1));
    @(negedge clk);
    checkOutput("calc_no_valid", 64'(req_if.req_valid), 64'(0));
    @(negedge clk);
    checkOutput("req_latency", 64'(req_if.req_valid), 64'(1));
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!str_out.done && n < 400);
    checkOutput({name, "_done_seen"}, 64'(str_out.done), 64'(1));
    checkOutput({name, "_bursts_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic runVec(input vec_t v, input logic [DMA_IDX_W-1:0] idx, input string name);
    desc[idx].src_addr  = v.addr;
    desc[idx].num_bytes = v.nbytes;
    desc[idx].rd_mode   = v.fixed;
    pushExp(v.a0, v.l0, v.fixed);
    if (v.n > 1) pushExp(v.a1, v.l1, v.fixed);
    stall_left = v.stall;
    applyStimulus(idx);
    waitDone(name);
  endtask

  // Ready driver: optionally holds ready low for a number of valid cycles
  initial begin
    req_if.req_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && req_if.req_valid) begin
        req_if.req_ready = 1'b0;
        stall_left--;
      end else begin
        req_if.req_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on handshake, done pulse timing, stall stability
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (done_pend || str_out.done) checkOutput("done_pulse", 64'(str_out.done), 64'(done_pend));
        done_pend = 1'b0;
        if (req_if.req_valid && req_if.req_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_req: got addr 0x%0h alen %0d, required no request",
                     req_if.req_addr, req_if.req_alen);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("req_addr", 64'(req_if.req_addr), 64'(cur.addr));
            checkOutput("req_alen", 64'(req_if.req_alen), 64'(cur.alen));
            checkOutput("req_burst", 64'(req_if.req_burst), 64'(cur.burst));
            checkOutput("req_size", 64'(req_if.req_size), 64'(2));
            if (exp_q.size() == 0) done_pend = 1'b1;
          end
        end
        if (req_if.req_valid && !req_if.req_ready) begin
          if (stall_prev) begin
            checkOutput("stall_addr_stable", 64'(req_if.req_addr), 64'(stall_addr));
            checkOutput("stall_alen_stable", 64'(req_if.req_alen), 64'(stall_alen));
          end
          stall_prev = 1'b1;
          stall_addr = req_if.req_addr;
          stall_alen = req_if.req_alen;
        end else begin
          stall_prev = 1'b0;
        end
      end else begin
        done_pend  = 1'b0;
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 32'd64,   1'b0, 0, 1, 32'h0000_1000, 32'h0,         8'd15,  8'd0};
    vecs[1] = '{32'h0000_0FF0, 32'd64,   1'b0, 0, 2, 32'h0000_0FF0, 32'h0000_1000, 8'd3,   8'd11};
    vecs[2] = '{32'h0000_0000, 32'd2048, 1'b0, 5, 2, 32'h0000_0000, 32'h0000_0400, 8'd255, 8'd255};
    vecs[3] = '{32'h0000_2000, 32'd100,  1'b1, 0, 2, 32'h0000_2000, 32'h0000_2000, 8'd15,  8'd8};
    vecs[4] = '{32'h0000_3000, 32'd3,    1'b1, 0, 1, 32'h0000_3000, 32'h0,         8'd0,   8'd0};
    vecs[5] = '{32'h0000_4000, 32'd5,    1'b0, 2, 1, 32'h0000_4000, 32'h0,         8'd1,   8'd0};
    vecs[6] = '{32'hFFFF_FFF0, 32'd32,   1'b0, 0, 2, 32'hFFFF_FFF0, 32'h0000_0000, 8'd3,   8'd3};

    for (int i = 0; i < DMA_NUM_DESC; i++) desc[i] = '0;
    str_in  = '0;
    abort_i = 1'b0;
    clear_i = 1'b0;

    #1;
    checkOutput("rst_req_valid", 64'(req_if.req_valid), 64'(0));
    checkOutput("rst_req_addr", 64'(req_if.req_addr), 64'(0));
    checkOutput("rst_req_alen", 64'(req_if.req_alen), 64'(0));
    checkOutput("rst_req_burst", 64'(req_if.req_burst), 64'(1));
    checkOutput("rst_done", 64'(str_out.done), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) runVec(vecs[i], 0, $sformatf("vec%0d", i));

    $display("[TB] abort during first request, then back-to-back idx 1");
    desc[0].src_addr  = 32'h0;
    desc[0].num_bytes = 32'd2048;
    desc[0].rd_mode   = 1'b0;
    pushExp(32'h0, 8'd255, 1'b0);
    stall_left = 3;
    applyStimulus(0);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    waitDone("abort");
    runVec(vecs[0], 1, "after_abort");

    $display("[TB] asynchronous reset while request is pending");
    desc[0].src_addr  = 32'h0000_8000;
    desc[0].num_bytes = 32'd2048;
    stall_left = 100;
    applyStimulus(0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_req_valid", 64'(req_if.req_valid), 64'(0));
    checkOutput("arst_req_addr", 64'(req_if.req_addr), 64'(0));
    checkOutput("arst_req_alen", 64'(req_if.req_alen), 64'(0));
    checkOutput("arst_req_burst", 64'(req_if.req_burst), 64'(1));
    checkOutput("arst_done", 64'(str_out.done), 64'(0));
    checkOutput("arst_busy", 64'(busy), 64'(0));
    stall_left = 0;
    @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] clear while in CALC");
    desc[0].src_addr  = 32'h0000_1000;
    desc[0].num_bytes = 32'd64;
    @(posedge clk); #1;
    str_in.valid = 1'b1;
    str_in.idx   = 1'b0;
    @(posedge clk); #1;
    str_in.valid = 1'b0;
    checkOutput("clear_busy_calc", 64'(busy), 64'(1));
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    checkOutput("clear_busy_idle", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("clear_no_req", 64'(req_if.req_valid), 64'(0));
    end
    runVec(vecs[1], 0, "after_clear");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_streamer.md
# dma_streamer

Per-direction DMA streamer: the responder to the DMA FSM's stream request (`valid`, `idx`). It fetches the selected descriptor, splits the transfer into AXI4-legal burst requests for the AXI interface, and pulses `done` once the last burst address has been accepted. Two instances are used: one read-side (`RD_STREAM=1`, source address) and one write-side (`RD_STREAM=0`, destination address). It sits between the DMA FSM and the AXI master address channel.

## Interface
- `RD_STREAM`, 1: 1 uses `src_addr`/`rd_mode`; 0 uses `dst_addr`/`wr_mode`.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: AXI data width; `BYTES = DATA_W/8`.
- `BYTES_W`, 32: width of the `num_bytes` field.
- `MAX_BEATS`, 256: maximum INCR burst length. FIXED bursts are always capped at 16.
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `dma_desc_i`  input  `s_dma_desc_t[DMA_NUM_DESC]`  descriptors. Fields used: `src_addr`, `dst_addr`, `num_bytes`, `rd_mode`, `wr_mode` (0 = INCR, 1 = FIXED).
- `dma_stream_i`  input  `s_dma_str_in_t`  request from the FSM: `valid`, `idx`.
- `dma_stream_o`  output  `s_dma_str_out_t`  `done`, a one-cycle pulse.
- `dma_abort_i`  input  1  abort request.
- `clear_dma_i`  input  1  synchronous return to IDLE.
- `req_valid_o` / `req_ready_i`  out / in  1  burst request handshake.
- `req_addr_o`  output  `ADDR_W`  burst start address.
- `req_alen_o`  output  8  AXI length (beats − 1).
- `req_size_o`  output  3  `log2(BYTES)`, constant.
- `req_burst_o`  output  2  `01` INCR, `00` FIXED.
- `busy_o`  output  1  state is not IDLE.

## Operation
- **IDLE**
  - On `dma_stream_i.valid`, latch `dma_desc_i[idx]`:
    - `addr` ← the selected address;
    - `beats_left` ← ceil(`num_bytes`/`BYTES`);
    - `mode` ← the selected mode.
  - Go to CALC.
  - `num_bytes == 0` is never requested by the FSM; if it occurs, go straight to DONE.
- **CALC** computes `beats` = min(`beats_left`, cap, `to4k`).
  - cap = `MAX_BEATS` for INCR, 16 for FIXED.
  - `to4k` = (4096 − `addr[11:0]`)/`BYTES` for INCR; ignored for FIXED.
  - Register `req_alen = beats − 1`, then go to REQ.
- **REQ**
  - Assert `req_valid_o`. Address, length and burst stay stable until `req_ready_i`.
  - On handshake:
    - `beats_left` −= `beats`;
    - `addr` += `beats·BYTES` for INCR; unchanged for FIXED.
  - Go to DONE if `beats_left == 0` or `abort_latched`; otherwise go to CALC.
- **DONE** asserts `dma_stream_o.done` for one cycle, then returns to IDLE.
- Abort handling:
  - `dma_abort_i` sets `abort_latched` in any non-IDLE state.
  - The current REQ is never withdrawn; it completes its handshake, then the block goes to DONE.
  - `abort_latched` clears in IDLE.
- `clear_dma_i` forces IDLE from any state and clears `abort_latched`. It takes priority over every other transition.
- Arithmetic:
  - `beats_left` is `BYTES_W` bits; no underflow is possible because `beats` ≤ `beats_left`.
  - `addr` wraps modulo 2^`ADDR_W`.
  - The low `log2(BYTES)` address bits pass through unchanged. Unaligned starts are the AXI interface's concern.

## Timing
- Reset values: state IDLE, `req_valid_o` 0, `req_addr_o` 0, `req_alen_o` 0, `req_burst_o` `01`, `done` 0, `busy_o` 0.
- Latency: `valid` sampled at edge N → CALC at N+1 → `req_valid_o` high from N+2.
- Each further burst costs one CALC cycle after the previous handshake.
- `done` is high exactly in the cycle after the final handshake. The FSM's `idx` is still the old one in that cycle, which is required.
- In IDLE, `dma_stream_i.valid` is accepted in the cycle after DONE. The FSM may present the next `idx` immediately.
- `req_ready_i` high in the same cycle `req_valid_o` rises completes the handshake in that cycle.
- All outputs are registered or decoded from the state register only. There is no combinational path from `req_ready_i` to `req_valid_o`.
- An asynchronous reset mid-burst drops `req_valid_o` immediately. No `done` is issued.

## Structure
- Add `dma_strm_st_t` (IDLE, CALC, REQ, DONE) and the AXI burst encodings to `dma_utils_pkg`.
- Add one sub-module, `dma_burst_calc`: purely combinational min(`beats_left`, cap, `to4k`). It is reused by both instances.

## Test plan
- INCR, `addr` 0x1000, 64 B, DATA_W 32 → 1 request: `addr` 0x1000, `alen` 15, `size` 2, `burst` 01; `done` 1 cycle after the handshake.
- 4 KB crossing, `addr` 0x0FF0, 64 B → `addr` 0x0FF0 `alen` 3, then `addr` 0x1000 `alen` 11; one `done`.
- 2048 B at 0x0 → `alen` 255 at 0x000, then `alen` 255 at 0x400. `req_ready_i` held low 5 cycles on the first request: address and length stay stable.
- FIXED, `addr` 0x2000, 100 B → `alen` 15 then `alen` 8, both at 0x2000, `burst` 00. 3 B → a single `alen` 0.
- Abort asserted during the first REQ of a 2048 B transfer → that request completes, `done` pulses, no second request. A back-to-back descriptor `idx` 1 is accepted the cycle after.
- Asynchronous reset while `req_valid_o` is high → all outputs at reset values immediately. `clear_dma_i` in CALC → IDLE next cycle with no `done`.
